// File: rtl/nios_tester_spi_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// nios_tester_spi_pkg : shared register map and status/control bit layout
// Rev 1.0
// -----------------------------------------------------------------------------
package nios_tester_spi_pkg;

  localparam int DEFAULT_DATA_BITS = 8;

  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  localparam int BIT_ROE  = 3;
  localparam int BIT_TOE  = 4;
  localparam int BIT_TUR  = 5;
  localparam int BIT_TRDY = 6;
  localparam int BIT_RRDY = 7;
  localparam int BIT_E    = 8;
  localparam int BIT_SSA  = 9;

  // Only status bits 3..8 can raise an interrupt.
  localparam logic [15:0] IRQ_MASK = 16'h01F8;

  function automatic logic [15:0] status_word(input logic roe, input logic toe,
                                              input logic tur, input logic trdy,
                                              input logic rrdy, input logic ssa);
    logic [15:0] s;
    s           = '0;
    s[BIT_ROE]  = roe;
    s[BIT_TOE]  = toe;
    s[BIT_TUR]  = tur;
    s[BIT_TRDY] = trdy;
    s[BIT_RRDY] = rrdy;
    s[BIT_E]    = roe | toe | tur;
    s[BIT_SSA]  = ssa;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nios_tester_spi_slave_pin_sync.sv
`default_nettype none
// -----------------------------------------------------------------------------
// spi_pin_sync : N-stage input synchronizer with rise/fall pulses
// Rev 1.0
// -----------------------------------------------------------------------------
module spi_pin_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;
  logic [STAGES:0]   vld_q;

  // Edges are suppressed until the chain holds only post-reset samples, so a
  // level that was already present at reset release never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
      vld_q  <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      dly_q <= sync_q[STAGES-1];
      vld_q <= {vld_q[STAGES-1:0], 1'b1};
    end
  end

  assign rise_o = vld_q[STAGES] &  sync_q[STAGES-1] & ~dly_q;
  assign fall_o = vld_q[STAGES] & ~sync_q[STAGES-1] &  dly_q;

endmodule
`default_nettype wire

// File: rtl/nios_tester_spi_slave.sv
`default_nettype none
// -----------------------------------------------------------------------------
// nios_tester_spi_slave : mode-0 SPI slave behind an Avalon-style register port
// Rev 1.0
// -----------------------------------------------------------------------------
module nios_tester_spi_slave
  import nios_tester_spi_pkg::*;
#(
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  mem_addr,
  input  logic        spi_select,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe
);

  localparam int                BW       = $clog2(DATA_BITS);
  localparam logic [BW-1:0]     LAST_BIT = BW'(DATA_BITS - 1);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset_n(reset_n), .d_i(SCLK), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk(clk), .reset_n(reset_n), .d_i(SS_n), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  logic                 rd_act_q, wr_act_q;
  logic [15:0]          data_to_cpu_q, data_to_cpu_d;
  logic                 irq_q, irq_d;
  logic [DATA_BITS-1:0] shift_rx_q, shift_rx_d, shift_tx_q, shift_tx_d;
  logic [DATA_BITS-1:0] rx_hold_q, rx_hold_d, tx_hold_q, tx_hold_d;
  logic                 tx_primed_q, tx_primed_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic                 frame_q, frame_d, byte_seen_q, byte_seen_d;
  logic                 roe_q, roe_d, toe_q, toe_d, tur_q, tur_d, rrdy_q, rrdy_d;
  logic [15:0]          ctrl_q, ctrl_d;

  logic                 rd_act, wr_act, rd_acc, wr_acc, rx_rd, load;
  logic [DATA_BITS-1:0] rx_next;
  logic [15:0]          status_w;

  assign rd_act   = spi_select & ~read_n;
  assign wr_act   = spi_select & ~write_n;
  assign rd_acc   = rd_act & ~rd_act_q;
  assign wr_acc   = wr_act & ~wr_act_q;
  assign rx_rd    = rd_acc && (mem_addr == ADDR_RXDATA);
  assign rx_next  = {shift_rx_q[DATA_BITS-2:0], mosi_sync_q[SYNC_STAGES-1]};
  assign status_w = status_word(roe_q, toe_q, tur_q, ~tx_primed_q, rrdy_q, frame_q);

  always_comb begin
    data_to_cpu_d = data_to_cpu_q;
    shift_rx_d    = shift_rx_q;
    shift_tx_d    = shift_tx_q;
    rx_hold_d     = rx_hold_q;
    tx_hold_d     = tx_hold_q;
    tx_primed_d   = tx_primed_q;
    bitcnt_d      = bitcnt_q;
    frame_d       = frame_q;
    byte_seen_d   = byte_seen_q;
    roe_d         = roe_q;
    toe_d         = toe_q;
    tur_d         = tur_q;
    rrdy_d        = rrdy_q;
    ctrl_d        = ctrl_q;
    load          = 1'b0;

    // Clears come first so that an error raised in the same clk wins.
    if (wr_acc && mem_addr == ADDR_STATUS) begin
      roe_d = 1'b0;
      toe_d = 1'b0;
      tur_d = 1'b0;
    end
    if (wr_acc && mem_addr == ADDR_CONTROL) ctrl_d = data_from_cpu & IRQ_MASK;

    if (rd_acc) begin
      case (mem_addr)
        ADDR_RXDATA:  data_to_cpu_d = 16'(rx_hold_q);
        ADDR_STATUS:  data_to_cpu_d = status_w;
        ADDR_CONTROL: data_to_cpu_d = ctrl_q;
        default:      data_to_cpu_d = '0;
      endcase
      if (rx_rd) rrdy_d = 1'b0;
    end

    if (ss_fall) begin
      frame_d     = 1'b1;
      bitcnt_d    = '0;
      byte_seen_d = 1'b0;
      load        = 1'b1;
    end else if (frame_q) begin
      if (sclk_rise) begin
        shift_rx_d = rx_next;
        if (bitcnt_q == LAST_BIT) begin
          rx_hold_d   = rx_next;
          if (rrdy_q && !rx_rd) roe_d = 1'b1;
          rrdy_d      = 1'b1;
          bitcnt_d    = '0;
          byte_seen_d = 1'b1;
        end else begin
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end else if (sclk_fall) begin
        if (bitcnt_q != '0)  shift_tx_d = shift_tx_q << 1;
        else if (byte_seen_q) load = 1'b1;
      end
      if (ss_rise) begin
        frame_d  = 1'b0;
        bitcnt_d = '0;
      end
    end

    if (load) begin
      if (tx_primed_q) begin
        shift_tx_d = tx_hold_q;
      end else begin
        shift_tx_d = '0;
        tur_d      = 1'b1;
      end
      tx_primed_d = 1'b0;
    end

    // A write landing on a reload sees the holding register already drained.
    if (wr_acc && mem_addr == ADDR_TXDATA) begin
      if (tx_primed_d) begin
        toe_d = 1'b1;
      end else begin
        tx_hold_d   = data_from_cpu[DATA_BITS-1:0];
        tx_primed_d = 1'b1;
      end
    end

    irq_d = |(status_w & ctrl_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mosi_sync_q   <= '0;
      rd_act_q      <= 1'b0;
      wr_act_q      <= 1'b0;
      data_to_cpu_q <= '0;
      irq_q         <= 1'b0;
      shift_rx_q    <= '0;
      shift_tx_q    <= '0;
      rx_hold_q     <= '0;
      tx_hold_q     <= '0;
      tx_primed_q   <= 1'b0;
      bitcnt_q      <= '0;
      frame_q       <= 1'b0;
      byte_seen_q   <= 1'b0;
      roe_q         <= 1'b0;
      toe_q         <= 1'b0;
      tur_q         <= 1'b0;
      rrdy_q        <= 1'b0;
      ctrl_q        <= '0;
    end else begin
      mosi_sync_q[0] <= MOSI;
      for (int i = 1; i < SYNC_STAGES; i++) mosi_sync_q[i] <= mosi_sync_q[i-1];
      rd_act_q      <= rd_act;
      wr_act_q      <= wr_act;
      data_to_cpu_q <= data_to_cpu_d;
      irq_q         <= irq_d;
      shift_rx_q    <= shift_rx_d;
      shift_tx_q    <= shift_tx_d;
      rx_hold_q     <= rx_hold_d;
      tx_hold_q     <= tx_hold_d;
      tx_primed_q   <= tx_primed_d;
      bitcnt_q      <= bitcnt_d;
      frame_q       <= frame_d;
      byte_seen_q   <= byte_seen_d;
      roe_q         <= roe_d;
      toe_q         <= toe_d;
      tur_q         <= tur_d;
      rrdy_q        <= rrdy_d;
      ctrl_q        <= ctrl_d;
    end
  end

  assign data_to_cpu = data_to_cpu_q;
  assign irq         = irq_q;
  assign MISO        = shift_tx_q[DATA_BITS-1];
  assign MISO_oe     = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_nios_tester_spi_slave.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_nios_tester_spi_slave : directed bench with a mode-0 master at clk/8
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_nios_tester_spi_slave;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  mem_addr = '0;
  logic        spi_select = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [15:0] data_from_cpu = '0;
  logic [15:0] data_to_cpu;
  logic        irq;
  logic        SCLK = 1'b0;
  logic        SS_n = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic        MISO_oe;

  int n_checks = 0;
  int n_fail   = 0;

  nios_tester_spi_slave #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .spi_select(spi_select),
    .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .irq(irq), .SCLK(SCLK), .SS_n(SS_n),
    .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe)
  );

  always #8 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    mem_addr = a; data_from_cpu = d; spi_select = 1'b1; write_n = 1'b0;
    @(negedge clk);
    write_n = 1'b1; spi_select = 1'b0;
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    mem_addr = a; spi_select = 1'b1; read_n = 1'b0;
    @(negedge clk);
    d = data_to_cpu;
    read_n = 1'b1; spi_select = 1'b0;
    @(negedge clk);
  endtask

  task automatic ss_low();
    @(negedge clk);
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ss_high();
    repeat (4) @(negedge clk);
    SS_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic m);
    MOSI = b;
    repeat (4) @(negedge clk);
    m = MISO;
    SCLK = 1'b1;
    repeat (4) @(negedge clk);
    SCLK = 1'b0;
  endtask

  task automatic byte_xfer(input logic [7:0] mo, output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) bit_xfer(mo[i], mi[i]);
  endtask

  initial begin
    logic [15:0] rd;
    logic [7:0]  mi;
    logic        mb;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dout", data_to_cpu, 16'h0000);
    check("rst_irq", {15'h0, irq}, 16'h0000);
    check("rst_miso", {15'h0, MISO}, 16'h0000);
    check("rst_oe", {15'h0, MISO_oe}, 16'h0000);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    cpu_read(3'd2, rd); check("rst_status", rd, 16'h0040);
    cpu_read(3'd3, rd); check("rst_ctrl", rd, 16'h0000);
    cpu_read(3'd0, rd); check("rst_rx", rd, 16'h0000);
    cpu_write(3'd6, 16'hFFFF);
    cpu_read(3'd6, rd); check("unmapped_rd", rd, 16'h0000);
    cpu_read(3'd2, rd); check("unmapped_wr", rd, 16'h0040);

    // Test 1: one frame, tx 0xA5 out, 0x3C in
    cpu_write(3'd1, 16'h00A5);
    cpu_read(3'd2, rd); check("t1_primed", rd, 16'h0000);
    ss_low();
    check("t1_oe_on", {15'h0, MISO_oe}, 16'h0001);
    byte_xfer(8'h3C, mi); check("t1_miso", {8'h0, mi}, 16'h00A5);
    ss_high();
    check("t1_oe_off", {15'h0, MISO_oe}, 16'h0000);
    cpu_read(3'd2, rd); check("t1_status", rd, 16'h01E0);
    cpu_read(3'd0, rd); check("t1_rx", rd, 16'h003C);
    cpu_read(3'd2, rd); check("t1_rrdy_clr", rd, 16'h0160);
    cpu_write(3'd2, 16'h0000);
    cpu_read(3'd2, rd); check("t1_st_clr", rd, 16'h0040);

    // Test 2: three back-to-back bytes, none read
    ss_low();
    byte_xfer(8'h01, mi); check("t2_miso0", {8'h0, mi}, 16'h0000);
    byte_xfer(8'h02, mi);
    byte_xfer(8'h03, mi);
    ss_high();
    cpu_read(3'd2, rd); check("t2_status", rd, 16'h01E8);
    cpu_write(3'd2, 16'h0000);
    cpu_read(3'd2, rd); check("t2_roe_clr", rd, 16'h00C0);
    cpu_read(3'd0, rd); check("t2_rx", rd, 16'h0003);
    cpu_read(3'd2, rd); check("t2_st_end", rd, 16'h0040);

    // Test 3: underrun with TUR interrupt enabled
    cpu_write(3'd3, 16'h0020);
    cpu_read(3'd3, rd); check("t3_ctrl", rd, 16'h0020);
    check("t3_irq_pre", {15'h0, irq}, 16'h0000);
    SS_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("t3_irq_tur", {15'h0, irq}, 16'h0000);
    @(posedge clk);
    #1 check("t3_irq_rise", {15'h0, irq}, 16'h0001);
    @(negedge clk);
    repeat (4) @(negedge clk);
    byte_xfer(8'h81, mi); check("t3_miso", {8'h0, mi}, 16'h0000);
    ss_high();
    cpu_read(3'd2, rd); check("t3_status", rd, 16'h01E0);
    cpu_read(3'd0, rd); check("t3_rx", rd, 16'h0081);
    cpu_write(3'd2, 16'h0000);
    check("t3_irq_clr", {15'h0, irq}, 16'h0000);
    cpu_write(3'd3, 16'h0000);

    // Test 4: tx overrun drops the second write
    cpu_write(3'd1, 16'h0011);
    cpu_write(3'd1, 16'h0022);
    cpu_read(3'd2, rd); check("t4_toe", rd, 16'h0110);
    ss_low();
    byte_xfer(8'h77, mi); check("t4_miso", {8'h0, mi}, 16'h0011);
    ss_high();
    cpu_read(3'd2, rd); check("t4_status", rd, 16'h01F0);
    cpu_read(3'd0, rd); check("t4_rx", rd, 16'h0077);
    cpu_write(3'd2, 16'h0000);

    // Test 5: aborted partial byte, then a full frame
    ss_low();
    for (int i = 0; i < 5; i++) bit_xfer(1'b1, mb);
    ss_high();
    cpu_read(3'd2, rd); check("t5_partial", rd, 16'h0160);
    ss_low();
    byte_xfer(8'hF0, mi);
    ss_high();
    cpu_read(3'd2, rd); check("t5_status", rd, 16'h01E0);
    cpu_read(3'd0, rd); check("t5_rx", rd, 16'h00F0);
    cpu_write(3'd2, 16'h0000);

    // Test 6: reset mid-frame after 3 bits
    cpu_write(3'd3, 16'h0020);
    ss_low();
    for (int i = 0; i < 3; i++) bit_xfer(1'b1, mb);
    cpu_read(3'd2, rd); check("t6_mid_status", rd, 16'h0360);
    check("t6_mid_irq", {15'h0, irq}, 16'h0001);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t6_rst_dout", data_to_cpu, 16'h0000);
    check("t6_rst_irq", {15'h0, irq}, 16'h0000);
    check("t6_rst_oe", {15'h0, MISO_oe}, 16'h0000);
    check("t6_rst_miso", {15'h0, MISO}, 16'h0000);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) bit_xfer(1'b0, mb);
    check("t6_ignored_oe", {15'h0, MISO_oe}, 16'h0000);
    cpu_read(3'd2, rd); check("t6_status", rd, 16'h0040);
    cpu_read(3'd3, rd); check("t6_ctrl", rd, 16'h0000);
    cpu_read(3'd0, rd); check("t6_rx_rst", rd, 16'h0000);
    ss_high();
    cpu_write(3'd1, 16'h00C3);
    ss_low();
    byte_xfer(8'h5A, mi); check("t6_miso", {8'h0, mi}, 16'h00C3);
    ss_high();
    cpu_read(3'd0, rd); check("t6_rx", rd, 16'h005A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
